// File: rtl/restoring_div_4bits_if.sv
// ============================================================================
// Module      : restoring_div_4bits_if
// Description : Request/result bundle for the 4-bit restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface restoring_div_4bits_if;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  modport master (
    output start, A, B,
    input  Q, R, busy, done, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output Q, R, busy, done, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/restoring_div_4bits.sv
// ============================================================================
// Module      : restoring_div_4bits
// Description : Unsigned 4-bit restoring divider, one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module restoring_div_4bits (
  input  wire logic                   clk,
  input  wire logic                   reset,
  restoring_div_4bits_if.slave        io_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;

  logic [3:0] r_dvd;
  logic [3:0] r_dvs;
  logic [4:0] r_pr;
  logic [1:0] r_cnt;
  logic [3:0] r_qw;
  logic [3:0] r_q;
  logic [3:0] r_r;
  logic       r_dbz;

  logic       w_accept;
  logic       w_last;
  logic [4:0] w_t;
  logic [4:0] w_b;
  logic [4:0] w_g;
  logic [4:0] w_p;
  logic [5:0] w_c;
  logic [4:0] w_d;
  logic [4:0] w_pr_nxt;
  logic [3:0] w_qw_nxt;
  logic       w_unused_pr_msb;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && io_bus.start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          w_next = (io_bus.B == 4'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (io_bus.start) begin
          w_next = (io_bus.B == 4'd0) ? S_DONE : S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Trial subtraction T - B; every borrow is a flat sum of generate/propagate products.
  assign w_t = {r_pr[3:0], r_dvd[3]};
  assign w_b = {1'b0, r_dvs};
  assign w_g = ~w_t & w_b;
  assign w_p = ~(w_t ^ w_b);

  assign w_c[0] = 1'b0;
  assign w_c[1] = w_g[0];
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  assign w_c[5] = w_g[4] | (w_p[4] & w_g[3]) | (w_p[4] & w_p[3] & w_g[2])
                | (w_p[4] & w_p[3] & w_p[2] & w_g[1])
                | (w_p[4] & w_p[3] & w_p[2] & w_p[1] & w_g[0]);

  assign w_d      = w_t ^ w_b ^ w_c[4:0];
  assign w_pr_nxt = w_c[5] ? w_t : w_d;
  assign w_qw_nxt = {r_qw[2:0], ~w_c[5]};

  // The remainder is always below the divisor after a step, so PR[4] is never fed back.
  assign w_unused_pr_msb = r_pr[4];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dvd <= 4'd0;
      r_dvs <= 4'd0;
      r_pr  <= 5'd0;
      r_cnt <= 2'd0;
      r_qw  <= 4'd0;
      r_q   <= 4'd0;
      r_r   <= 4'd0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= io_bus.A;
      r_dvs <= io_bus.B;
      r_pr  <= 5'd0;
      r_cnt <= 2'd0;
      r_qw  <= 4'd0;
      r_dbz <= 1'b0;
      if (io_bus.B == 4'd0) begin
        r_q   <= 4'hF;
        r_r   <= io_bus.A;
        r_dbz <= 1'b1;
      end
    end else if (r_state == S_RUN) begin
      r_pr  <= w_pr_nxt;
      r_qw  <= w_qw_nxt;
      r_dvd <= {r_dvd[2:0], 1'b0};
      r_cnt <= r_cnt + 2'd1;
      if (w_last) begin
        r_q <= w_qw_nxt;
        r_r <= w_pr_nxt[3:0];
      end
    end
  end

  assign io_bus.Q           = r_q;
  assign io_bus.R           = r_r;
  assign io_bus.div_by_zero = r_dbz;
  assign io_bus.busy        = (r_state == S_RUN);
  assign io_bus.done        = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: doc/restoring_div_4bits.md
RESTORING_DIV_4BITS -- requirements
Module: restoring_div_4bits

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-005 A  input  4  unsigned dividend, captured when start is accepted.
REQ-006 B  input  4  unsigned divisor, captured when start is accepted.
REQ-007 Q  output  4  quotient, registered.
REQ-008 R  output  4  remainder, registered.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 div_by_zero  output  1  high when the result belongs to a B==0 request; held with Q and R.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, start=1 on a clock edge SHALL latch A and B.
REQ-014 That same edge SHALL clear the 5-bit partial remainder PR, clear the 2-bit iteration counter, and clear div_by_zero.
REQ-015 That same edge SHALL enter RUN if B!=0.
REQ-016 If B==0 at that edge, the FSM SHALL instead enter DONE with Q=4'hF, R=A and div_by_zero=1.
REQ-017 Each RUN edge SHALL form T = {PR[3:0], dividend MSB}, then shift the latched dividend left by one.
REQ-018 Each RUN edge SHALL compute D = T - {1'b0,B} with a 5-bit borrow-lookahead subtractor.
REQ-019 The subtractor SHALL use per bit g = ~t & b and p = ~(t ^ b), with borrows computed in lookahead form and not rippled.
REQ-020 If no borrow-out occurs, PR SHALL take D and the quotient bit SHALL be 1; otherwise PR SHALL take T and the quotient bit SHALL be 0.
REQ-021 Quotient bits SHALL be produced MSB first, shifted into a working quotient register.
REQ-022 RUN SHALL last exactly 4 edges; the 4th RUN edge SHALL load Q and R = PR[3:0] and enter DONE.
REQ-023 Latency SHALL be as follows: start accepted at edge k leads to done high in the cycle after edge k+4 for a nonzero divisor, or in the cycle after edge k for a zero divisor.
REQ-024 done SHALL be high for exactly one cycle, the first cycle in DONE.
REQ-025 DONE SHALL fall back to IDLE on the next edge if start=0; if start=1 on that edge, a new request SHALL be accepted directly.
REQ-026 busy SHALL equal (state==RUN).
REQ-027 start SHALL be ignored while busy=1; latched operands SHALL stay unchanged and no second done SHALL result.
REQ-028 Q, R and div_by_zero SHALL hold their last result until the next done.
REQ-029 Q and R SHALL NOT change during RUN.
REQ-030 Results SHALL satisfy A = Q*B + R with R < B for every B!=0.
REQ-031 PR SHALL never exceed 5 bits, since 2*B-1 <= 29.

Reset
REQ-032 When reset=1 on a clock edge, the block SHALL enter IDLE.
REQ-033 The same reset edge SHALL clear Q, R, busy, done, div_by_zero, PR, the counter and the latched operands.
REQ-034 Reset SHALL take priority over start and over any in-flight RUN iteration.
REQ-035 A reset during RUN SHALL abort the operation with no done pulse and no update of Q or R.

Verification
REQ-036 The bench SHALL drive A=13, B=3, start for one cycle, and check busy high for 4 cycles, then done for 1 cycle with Q=4, R=1 and div_by_zero=0.
REQ-037 The bench SHALL check two extremes: A=15, B=1 gives Q=15, R=0; A=5, B=7 gives Q=0, R=5; both with 4-cycle latency.
REQ-038 The bench SHALL drive A=9, B=0 and check done one cycle after start with Q=15, R=9, div_by_zero=1 and busy never high.
REQ-039 The bench SHALL start 14/4, pulse start with 7/2 during RUN, and check a single done with Q=3, R=2 and no second result.
REQ-040 The bench SHALL start 11/2, assert reset at the 2nd RUN cycle, and check all outputs 0 next cycle and no done; a following 11/2 SHALL give Q=5, R=1.
REQ-041 The bench SHALL run all 256 A/B pairs back-to-back, with start asserted in the DONE cycle, and check results per REQ-030, or per REQ-016 for B=0.
